// File: rtl/codec_config_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : codec_config_seq_if
//  Purpose  : Command/response bundle between the codec configuration
//             sequencer (master) and the downstream I2C controller (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface codec_config_seq_if;
   logic        i2c_start;   // 1-cycle transfer request
   logic [23:0] i2c_data;    // {dev_addr, reg_addr[6:0], reg_val[8:0]}
   logic        i2c_done;    // transfer complete (level)
   logic        i2c_ack;     // all three bytes ACKed, valid with i2c_done

   modport master (output i2c_start, i2c_data, input  i2c_done, i2c_ack);
   modport slave  (input  i2c_start, i2c_data, output i2c_done, i2c_ack);
endinterface
`default_nettype wire

// File: rtl/codec_config_seq.sv
`default_nettype none
// ============================================================================
//  Module   : codec_config_seq
//  Purpose  : Power-up register sequencer for the audio codec. Walks a fixed
//             table of register writes and hands each one as a 24-bit word
//             to the I2C controller, with ACK checking and a settle gap.
//  Options  : CODEC_CFG_RETRY_EN - retry a NACKed word up to MAX_RETRY times
//             before flagging an error (otherwise any NACK is fatal).
//  Revision : 1.0  initial release
// ============================================================================
module codec_config_seq #(
   parameter logic [7:0] DEV_ADDR   = 8'h34,
   parameter int         NUM_REGS   = 10,
   parameter int         GAP_CYCLES = 1024
`ifdef CODEC_CFG_RETRY_EN
   ,
   parameter int         MAX_RETRY  = 3
`endif
) (
   input  wire logic          clk,
   input  wire logic          reset,
   input  wire logic          start,
   output      logic          busy,
   output      logic          done,
   output      logic          error,
   output      logic [3:0]    err_index,
   codec_config_seq_if.master i2c
);

   localparam int         GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);
`ifdef CODEC_CFG_RETRY_EN
   localparam int         RW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);
`endif

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_LOAD  = 4'd1,
      S_PULSE = 4'd2,
      S_HOLD  = 4'd3,
      S_WAIT  = 4'd4,
      S_CHECK = 4'd5,
      S_GAP   = 4'd6,
      S_FIN   = 4'd7,
      S_ERR   = 4'd8
   } state_t;

   state_t        state, state_n;
   logic [3:0]    idx, idx_n;
   logic [GW-1:0] gap_cnt, gap_cnt_n;
   logic          ack_q, ack_n;
   logic          busy_n, done_n, error_n, i2c_start_n;
   logic [3:0]    err_index_n;
   logic [23:0]   i2c_data_n;
`ifdef CODEC_CFG_RETRY_EN
   logic [RW-1:0] retries, retries_n;
`endif

   // Codec init table: {reg_addr[6:0], reg_val[8:0]}; unused slots write R15 (reset)
   function automatic logic [15:0] table_entry(input logic [3:0] i);
      logic [6:0] ra;
      logic [8:0] rv;
      case (i)
         4'd0:    begin ra = 7'd15; rv = 9'h000; end
         4'd1:    begin ra = 7'd0;  rv = 9'h017; end
         4'd2:    begin ra = 7'd1;  rv = 9'h017; end
         4'd3:    begin ra = 7'd2;  rv = 9'h079; end
         4'd4:    begin ra = 7'd3;  rv = 9'h079; end
         4'd5:    begin ra = 7'd4;  rv = 9'h012; end
         4'd6:    begin ra = 7'd5;  rv = 9'h000; end
         4'd7:    begin ra = 7'd6;  rv = 9'h000; end
         4'd8:    begin ra = 7'd7;  rv = 9'h00A; end
         4'd9:    begin ra = 7'd9;  rv = 9'h001; end
         default: begin ra = 7'd15; rv = 9'h000; end
      endcase
      return {ra, rv};
   endfunction

   // Next-state and next-output logic; a start pulse overrides every state
   always_comb begin
      state_n     = state;
      idx_n       = idx;
      gap_cnt_n   = gap_cnt;
      ack_n       = ack_q;
      busy_n      = busy;
      done_n      = done;
      error_n     = error;
      err_index_n = err_index;
      i2c_start_n = 1'b0;
      i2c_data_n  = i2c.i2c_data;
`ifdef CODEC_CFG_RETRY_EN
      retries_n   = retries;
`endif
      if (start) begin
         state_n     = S_LOAD;
         idx_n       = '0;
         done_n      = 1'b0;
         error_n     = 1'b0;
         err_index_n = '0;
         busy_n      = 1'b1;
`ifdef CODEC_CFG_RETRY_EN
         retries_n   = '0;
`endif
      end else begin
         case (state)
            S_IDLE: ;
            // Data and start pulse are registered together so data is stable with the pulse
            S_LOAD: begin
               i2c_data_n  = {DEV_ADDR, table_entry(idx)};
               i2c_start_n = 1'b1;
               state_n     = S_PULSE;
            end
            S_PULSE: state_n = S_HOLD;
            // Controller's done may still be high from the previous word here
            S_HOLD:  state_n = S_WAIT;
            S_WAIT: begin
               if (i2c.i2c_done) begin
                  ack_n   = i2c.i2c_ack;
                  state_n = S_CHECK;
               end
            end
            S_CHECK: begin
               if (ack_q) begin
                  if (idx == LAST_IDX) begin
                     state_n = S_FIN;
                  end else begin
                     idx_n     = idx + 4'd1;
                     gap_cnt_n = '0;
                     state_n   = S_GAP;
`ifdef CODEC_CFG_RETRY_EN
                     retries_n = '0;
`endif
                  end
               end else begin
`ifdef CODEC_CFG_RETRY_EN
                  if (retries < MAX_R) begin
                     retries_n = retries + 1'b1;
                     gap_cnt_n = '0;
                     state_n   = S_GAP;
                  end else begin
                     state_n   = S_ERR;
                  end
`else
                  state_n = S_ERR;
`endif
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) state_n = S_LOAD;
               else                     gap_cnt_n = gap_cnt + 1'b1;
            end
            S_FIN: begin
               done_n  = 1'b1;
               busy_n  = 1'b0;
               state_n = S_IDLE;
            end
            S_ERR: begin
               error_n     = 1'b1;
               err_index_n = idx;
               busy_n      = 1'b0;
               state_n     = S_IDLE;
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   // State and output registers; reset takes priority over start
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         idx           <= '0;
         gap_cnt       <= '0;
         ack_q         <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         err_index     <= '0;
         i2c.i2c_start <= 1'b0;
         i2c.i2c_data  <= '0;
`ifdef CODEC_CFG_RETRY_EN
         retries       <= '0;
`endif
      end else begin
         state         <= state_n;
         idx           <= idx_n;
         gap_cnt       <= gap_cnt_n;
         ack_q         <= ack_n;
         busy          <= busy_n;
         done          <= done_n;
         error         <= error_n;
         err_index     <= err_index_n;
         i2c.i2c_start <= i2c_start_n;
         i2c.i2c_data  <= i2c_data_n;
`ifdef CODEC_CFG_RETRY_EN
         retries       <= retries_n;
`endif
      end
   end

endmodule
`default_nettype wire
